// File: rtl/vec_mem_seq_pkg.sv
// Shared definitions for the vector memory sequencer.
//   - sequencer state encoding
//   - vector geometry (words per vector, word width, tag width)
//   - lane_get / lane_put helpers to read or replace one 16-bit word of a 256-bit vector
package vec_mem_seq_pkg;

  localparam int unsigned NWORDS = 16;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned VEC_W  = NWORDS * WORD_W;
  localparam int unsigned TAG_W  = $clog2(NWORDS);

  typedef enum logic [2:0] {
    StIdle,
    StLdIssue,
    StLdDrain,
    StStIssue,
    StDone
  } state_e;

  // Word idx of a vector: bits [16*idx+15 : 16*idx].
  function automatic logic [WORD_W-1:0] lane_get(input logic [VEC_W-1:0] vec,
                                                 input logic [TAG_W-1:0] idx);
    return vec[int'(idx) * WORD_W +: WORD_W];
  endfunction

  // Copy of vec with word idx replaced by word.
  function automatic logic [VEC_W-1:0] lane_put(input logic [VEC_W-1:0]  vec,
                                                input logic [TAG_W-1:0]  idx,
                                                input logic [WORD_W-1:0] word);
    logic [VEC_W-1:0] res;
    res = vec;
    res[int'(idx) * WORD_W +: WORD_W] = word;
    return res;
  endfunction

endpackage

// File: rtl/vms_rd_pipe.sv
// Read-latency tracker for the memory sequencer.
// A Depth-stage shift register of {valid, tag}. Every cycle the current bus read (push,
// push_tag) enters stage 0; the last stage says which lane DataIn belongs to this cycle.
// Ports:
//   Clk1      clock
//   Reset     synchronous active-high reset, empties every stage
//   push      a read strobe is on the bus this cycle
//   push_tag  lane index of that read
//   pop_valid DataIn carries a requested word this cycle
//   pop_tag   lane index of that word
module vms_rd_pipe
  import vec_mem_seq_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic             Clk1,
  input  logic             Reset,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  output logic             pop_valid,
  output logic [TAG_W-1:0] pop_tag
);

  logic [Depth-1:0]            valid_q;
  logic [Depth-1:0][TAG_W-1:0] tag_q;

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      valid_q <= '0;
      tag_q   <= '0;
    end else begin
      valid_q[0] <= push;
      tag_q[0]   <= push_tag;
      for (int i = 1; i < int'(Depth); i++) begin
        valid_q[i] <= valid_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  assign pop_valid = valid_q[Depth-1];
  assign pop_tag   = tag_q[Depth-1];

endmodule

// File: rtl/vec_mem_seq.sv
// Multi-cycle memory sequencer between the CVP14 core and the 16-bit single-ported bus.
// Accepts one load/store request (1..16 words), issues one bus word per cycle starting the
// cycle after accept, packs returning load words into a 256-bit vector and pulses
// rsp_valid for one cycle on completion.
// Ports:
//   Clk1, Reset             clock, synchronous active-high reset
//   req_valid / req_ready   request handshake (ready only while idle)
//   req_store, req_vec      store/load select, vector qualifier (drives V)
//   req_base, req_last      first word address, word count minus one
//   req_wdata               store vector, word i at [16i+15:16i]
//   Addr, RD, WR, V         registered bus address and strobes
//   dataOut, DataIn         bus write data, bus read data (valid RD_LAT cycles after RD)
//   rsp_valid, rsp_data     completion pulse, last assembled load vector
module vec_mem_seq
  import vec_mem_seq_pkg::*;
#(
  parameter int unsigned RD_LAT = 1  // legal range 1..3
) (
  input  logic              Clk1,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic              req_vec,
  input  logic [15:0]       req_base,
  input  logic [TAG_W-1:0]  req_last,
  input  logic [VEC_W-1:0]  req_wdata,
  output logic [15:0]       Addr,
  output logic              RD,
  output logic              WR,
  output logic              V,
  output logic [WORD_W-1:0] dataOut,
  input  logic [WORD_W-1:0] DataIn,
  output logic              rsp_valid,
  output logic [VEC_W-1:0]  rsp_data
);

  state_e           state_q;
  logic [TAG_W-1:0] idx_q;    // lane currently on the bus
  logic [TAG_W-1:0] last_q;
  logic [VEC_W-1:0] wdata_q;
  logic [VEC_W-1:0] work_q;   // load vector being assembled

  logic             pipe_valid;
  logic [TAG_W-1:0] pipe_tag;

  // RD is registered, so the tag of the word on the bus is simply idx_q.
  vms_rd_pipe #(
    .Depth(RD_LAT)
  ) u_rd_pipe (
    .Clk1     (Clk1),
    .Reset    (Reset),
    .push     (RD),
    .push_tag (idx_q),
    .pop_valid(pipe_valid),
    .pop_tag  (pipe_tag)
  );

  assign req_ready = (state_q == StIdle);

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      last_q    <= '0;
      wdata_q   <= '0;
      work_q    <= '0;
      Addr      <= '0;
      RD        <= 1'b0;
      WR        <= 1'b0;
      V         <= 1'b0;
      dataOut   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;

      // Returning words are captured in whatever state they arrive.
      if (pipe_valid) begin
        work_q <= lane_put(work_q, pipe_tag, DataIn);
      end

      case (state_q)
        StIdle: begin
          if (req_valid) begin
            idx_q   <= '0;
            last_q  <= req_last;
            wdata_q <= req_wdata;
            work_q  <= '0;  // lanes above last must read back as zero
            Addr    <= req_base;
            V       <= req_vec;
            if (req_store) begin
              WR      <= 1'b1;
              dataOut <= lane_get(req_wdata, '0);
              state_q <= StStIssue;
            end else begin
              RD      <= 1'b1;
              state_q <= StLdIssue;
            end
          end
        end

        StLdIssue, StStIssue: begin
          if (idx_q == last_q) begin
            RD      <= 1'b0;
            WR      <= 1'b0;
            V       <= 1'b0;
            Addr    <= '0;
            dataOut <= '0;
            if (state_q == StStIssue) begin
              rsp_valid <= 1'b1;
              state_q   <= StDone;
            end else begin
              state_q <= StLdDrain;
            end
          end else begin
            idx_q <= idx_q + 1'b1;
            Addr  <= Addr + 16'd1;  // 16-bit modulo wrap is intended
            if (state_q == StStIssue) begin
              dataOut <= lane_get(wdata_q, idx_q + 1'b1);
            end
          end
        end

        StLdDrain: begin
          // Reads return in issue order, so tag == last is the final word.
          if (pipe_valid && (pipe_tag == last_q)) begin
            rsp_valid <= 1'b1;
            rsp_data  <= lane_put(work_q, pipe_tag, DataIn);
            state_q   <= StDone;
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
